// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_e;

  // Coin values in half-units.
  localparam logic [1:0] COIN_HALF = 2'd1;
  localparam logic [1:0] COIN_ONE  = 2'd2;

  // Fixed LED patterns; COLLECT shows the credit instead.
  localparam logic [3:0] LED_IDLE   = 4'b0000;
  localparam logic [3:0] LED_VEND   = 4'b1111;
  localparam logic [3:0] LED_REFUND = 4'b1001;

  // Value inserted this cycle; both keys together are worth 3 half-units.
  function automatic logic [1:0] coin_value(input logic k1, input logic k2);
    return (k1 ? COIN_HALF : 2'd0) + (k2 ? COIN_ONE : 2'd0);
  endfunction

endpackage

// File: rtl/vend_if.sv
// Key inputs and status outputs of the vending controller.
interface vend_if #(
  parameter int CREDIT_W = 4
);
  logic                key1;
  logic                key2;
  logic                dispense;
  logic                change_vld;
  logic [CREDIT_W-1:0] change_val;
  logic                busy;
  logic [3:0]          led;

  // Driver side: the debouncers / test stimulus.
  modport master (
    output key1, key2,
    input  dispense, change_vld, change_val, busy, led
  );

  // Controller side.
  modport slave (
    input  key1, key2,
    output dispense, change_vld, change_val, busy, led
  );
endinterface

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the COLLECT timeout and the VEND/REFUND
// hold. expire is high for the single cycle in which the count sits at 0.
module vend_timer #(
  parameter int TMR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  assign expire = run_q && (cnt_q == '0);

  // Next count: start wins over clear, then count down while running.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (clear) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: accumulates coin credit, then sequences
// dispense + change, or a refund after an idle timeout, and drives the LEDs.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_HALVES = 5,
  parameter int CREDIT_W     = 4,
  parameter int TIMEOUT_CYC  = 500_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int TMR_W        = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  vend_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_HALVES);
  // The timer is loaded on the edge that ends the coin (or entry) cycle and
  // expires when it reaches 0, so the loads are one and two short of the
  // nominal counts: the coin cycle itself is the first idle cycle.
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYC - 2);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC - 1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic                change_vld_q, change_vld_d;
  logic [CREDIT_W-1:0] change_val_q, change_val_d;
  logic                busy_q, busy_d;
  logic [3:0]          led_q, led_d;

  logic [CREDIT_W-1:0] add, sum;
  logic                tmr_start, tmr_clear, tmr_expire;
  logic [TMR_W-1:0]    tmr_load;

  assign add = CREDIT_W'(coin_value(bus.key1, bus.key2));
  assign sum = credit_q + add;

  vend_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tmr_start),
    .clear    (tmr_clear),
    .load_val (tmr_load),
    .expire   (tmr_expire)
  );

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    dispense_d   = 1'b0;
    change_vld_d = 1'b0;
    change_val_d = change_val_q;
    busy_d       = busy_q;
    led_d        = led_q;
    tmr_start    = 1'b0;
    tmr_clear    = 1'b0;
    tmr_load     = TO_LOAD;

    unique case (state_q)
      IDLE, COLLECT: begin
        if (add != '0) begin
          // In IDLE credit_q is 0, so sum is just the coin value.
          credit_d  = sum;
          tmr_start = 1'b1;
          if (sum >= PRICE) begin
            state_d      = VEND;
            dispense_d   = 1'b1;
            change_vld_d = 1'b1;
            change_val_d = sum - PRICE;
            busy_d       = 1'b1;
            led_d        = LED_VEND;
            tmr_load     = HOLD_LOAD;
          end else begin
            state_d = COLLECT;
            led_d   = 4'(sum);
          end
        end else if (state_q == COLLECT && tmr_expire) begin
          state_d      = REFUND;
          change_vld_d = 1'b1;
          change_val_d = credit_q;
          busy_d       = 1'b1;
          led_d        = LED_REFUND;
          tmr_start    = 1'b1;
          tmr_load     = HOLD_LOAD;
        end
      end
      VEND, REFUND: begin
        // Coins are ignored here; only the hold expiry matters.
        if (tmr_expire) begin
          state_d      = IDLE;
          credit_d     = '0;
          change_val_d = '0;
          busy_d       = 1'b0;
          led_d        = LED_IDLE;
          tmr_clear    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, credit and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      dispense_q   <= 1'b0;
      change_vld_q <= 1'b0;
      change_val_q <= '0;
      busy_q       <= 1'b0;
      led_q        <= LED_IDLE;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      dispense_q   <= dispense_d;
      change_vld_q <= change_vld_d;
      change_val_q <= change_val_d;
      busy_q       <= busy_d;
      led_q        <= led_d;
    end
  end

  assign bus.dispense   = dispense_q;
  assign bus.change_vld = change_vld_q;
  assign bus.change_val = change_val_q;
  assign bus.busy       = busy_q;
  assign bus.led        = led_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios followed by random
// coin traffic, all compared against a transaction-level model.
module tb_vend_ctrl;

  localparam int PRICE   = 5;
  localparam int CW      = 4;
  localparam int TIMEOUT = 20;
  localparam int HOLD    = 4;

  logic clk = 1'b0;
  logic rst_n;

  vend_if #(.CREDIT_W(CW)) bus ();

  vend_ctrl #(
    .PRICE_HALVES (PRICE),
    .CREDIT_W     (CW),
    .TIMEOUT_CYC  (TIMEOUT),
    .HOLD_CYC     (HOLD),
    .TMR_W        (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: credit in half-units, a busy flag with cycles of hold
  // left, and a count of coin-free cycles while collecting.
  int   m_credit, m_hold, m_quiet;
  bit   m_busy, m_collect;
  logic exp_disp, exp_cvld, exp_busy;
  logic [3:0] exp_cval, exp_led;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_hold = 0; m_quiet = 0; m_busy = 0; m_collect = 0;
    exp_disp = 0; exp_cvld = 0; exp_busy = 0; exp_cval = 0; exp_led = 0;
  endtask

  // Outputs expected in the cycle after keys k1/k2 were presented.
  task automatic model_step(input bit k1, input bit k2);
    int add;
    add = int'(k1) + 2 * int'(k2);
    exp_disp = 0;
    exp_cvld = 0;
    if (m_busy) begin
      m_hold--;
      if (m_hold == 0) begin
        m_busy = 0; m_credit = 0; exp_cval = 0; exp_led = 4'b0000;
      end
    end else if (add != 0) begin
      m_credit += add;
      m_quiet = 0;
      if (m_credit >= PRICE) begin
        m_busy = 1; m_collect = 0; m_hold = HOLD;
        exp_disp = 1; exp_cvld = 1;
        exp_cval = 4'(m_credit - PRICE);
        exp_led  = 4'b1111;
      end else begin
        m_collect = 1;
        exp_led = 4'(m_credit);
      end
    end else if (m_collect) begin
      m_quiet++;
      if (m_quiet == TIMEOUT - 1) begin
        m_busy = 1; m_collect = 0; m_hold = HOLD;
        exp_cvld = 1;
        exp_cval = 4'(m_credit);
        exp_led  = 4'b1001;
      end
    end
    exp_busy = m_busy;
  endtask

  task automatic check_all();
    check("dispense",   32'(bus.dispense),   32'(exp_disp));
    check("change_vld", 32'(bus.change_vld), 32'(exp_cvld));
    check("change_val", 32'(bus.change_val), 32'(exp_cval));
    check("busy",       32'(bus.busy),       32'(exp_busy));
    check("led",        32'(bus.led),        32'(exp_led));
  endtask

  // Called at a negedge: present keys for one cycle, then sample at the
  // following negedge and compare with the model.
  task automatic tick(input bit k1, input bit k2);
    bus.key1 = k1;
    bus.key2 = k2;
    model_step(k1, k2);
    @(negedge clk);
    bus.key1 = 1'b0;
    bus.key2 = 1'b0;
    check_all();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    bus.key1 = 1'b0;
    bus.key2 = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Exact price: 2 -> 4 -> 5.
    tick(1'b0, 1'b1);
    check("s2_led_2", 32'(bus.led), 32'h2);
    tick(1'b0, 1'b1);
    check("s2_led_4", 32'(bus.led), 32'h4);
    tick(1'b1, 1'b0);
    check("s2_disp", 32'(bus.dispense), 32'h1);
    check("s2_cval", 32'(bus.change_val), 32'h0);
    check("s2_led_f", 32'(bus.led), 32'hf);
    tick(1'b0, 1'b0);
    check("s2_disp_low", 32'(bus.dispense), 32'h0);
    quiet(HOLD - 1);
    check("s2_idle_led", 32'(bus.led), 32'h0);
    check("s2_idle_busy", 32'(bus.busy), 32'h0);

    // Overpay, starting in the first IDLE cycle after the hold.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("s3_disp", 32'(bus.dispense), 32'h1);
    check("s3_cval", 32'(bus.change_val), 32'h1);
    quiet(HOLD);

    // Simultaneous coins: 3 then 6.
    tick(1'b1, 1'b1);
    check("s4_led_3", 32'(bus.led), 32'h3);
    tick(1'b1, 1'b1);
    check("s4_disp", 32'(bus.dispense), 32'h1);
    check("s4_cval", 32'(bus.change_val), 32'h1);
    quiet(HOLD);

    // Timeout refund of 3, coins during the hold are ignored.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    quiet(TIMEOUT - 1);
    check("s5_cvld", 32'(bus.change_vld), 32'h1);
    check("s5_cval", 32'(bus.change_val), 32'h3);
    check("s5_led",  32'(bus.led), 32'h9);
    check("s5_disp", 32'(bus.dispense), 32'h0);
    tick(1'b1, 1'b1);
    check("s5_busy", 32'(bus.busy), 32'h1);
    check("s5_cval_held", 32'(bus.change_val), 32'h3);
    quiet(HOLD - 1);
    check("s5_cval_cleared", 32'(bus.change_val), 32'h0);

    // Coin in the expiry cycle wins over the refund.
    tick(1'b0, 1'b1);
    quiet(TIMEOUT - 2);
    tick(1'b1, 1'b0);
    check("s6_led", 32'(bus.led), 32'h3);
    check("s6_no_refund", 32'(bus.change_vld), 32'h0);
    check("s6_not_busy", 32'(bus.busy), 32'h0);
    quiet(TIMEOUT + HOLD + 2);

    // Reset asserted during VEND.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("s1_in_vend", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    check("s1_no_disp", 32'(bus.dispense), 32'h0);
    tick(1'b1, 1'b0);
    check("s1_accepts", 32'(bus.led), 32'h1);
    quiet(TIMEOUT + HOLD + 2);

    // Random traffic: bursts of coins mixed with long silences.
    for (int b = 0; b < 60; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        quiet(TIMEOUT + $urandom_range(0, 3));
      end else begin
        for (int i = 0; i < 8; i++)
          tick($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
